// File: rtl/calc_pkg.sv
// Shared types for the calculator control path: command encoding, sequencer states.
package calc_pkg;

  localparam int WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    CMD_NEW = 2'b00,
    CMD_ADD = 2'b01,
    CMD_ACC = 2'b10,
    CMD_CLR = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_HAVE_A = 2'b01,
    S_SETTLE = 2'b10,
    S_OUT    = 2'b11
  } state_e;

endpackage

// File: rtl/calc_flags.sv
// Carry/overflow flags for an add g = d + f (mod 2^WIDTH), derived without the carry chain.
module calc_flags #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] d_i,
  input  logic [WIDTH-1:0] f_i,
  input  logic [WIDTH-1:0] g_i,
  output logic             carry_o,
  output logic             ovf_o
);

  // A wrapped unsigned sum is always smaller than either operand.
  assign carry_o = (g_i < d_i);
  assign ovf_o   = (d_i[WIDTH-1] == f_i[WIDTH-1]) && (g_i[WIDTH-1] != d_i[WIDTH-1]);

endmodule

// File: rtl/calc_op_sequencer.sv
// Control stage in front of the external ripple adder: latches operands, waits for the
// carry to settle, captures sum/flags, and keeps a running accumulator.
module calc_op_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH         = WIDTH_DEFAULT,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_cmd,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] add_d,
  output logic [WIDTH-1:0] add_f,
  input  logic [WIDTH-1:0] add_g,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_carry,
  output logic             res_ovf,
  output logic             busy
);

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] add_d_q, add_d_d;
  logic [WIDTH-1:0] add_f_q, add_f_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_carry_q, res_carry_d;
  logic             res_ovf_q, res_ovf_d;

  logic             flag_carry, flag_ovf;
  logic             xfer;
  cmd_e             cmd;

  calc_flags #(.WIDTH(WIDTH)) u_flags (
    .d_i     (add_d_q),
    .f_i     (add_f_q),
    .g_i     (add_g),
    .carry_o (flag_carry),
    .ovf_o   (flag_ovf)
  );

  assign cmd      = cmd_e'(in_cmd);
  assign in_ready = (state_q == S_IDLE) || (state_q == S_HAVE_A);
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    op_a_d      = op_a_q;
    add_d_d     = add_d_q;
    add_f_d     = add_f_q;
    res_data_d  = res_data_q;
    res_carry_d = res_carry_q;
    res_ovf_d   = res_ovf_q;
    unique case (state_q)
      S_IDLE, S_HAVE_A: begin
        if (xfer) begin
          unique case (cmd)
            CMD_NEW: begin
              op_a_d  = in_data;
              state_d = S_HAVE_A;
            end
            CMD_ADD: begin
              // With no pending first operand, ADD degenerates to 0 + in_data.
              add_d_d = (state_q == S_HAVE_A) ? op_a_q : '0;
              add_f_d = in_data;
              cnt_d   = CNT_LOAD;
              state_d = S_SETTLE;
            end
            CMD_ACC: begin
              add_d_d = acc_q;
              add_f_d = in_data;
              cnt_d   = CNT_LOAD;
              state_d = S_SETTLE;
            end
            CMD_CLR: begin
              acc_d   = '0;
              state_d = S_IDLE;
            end
          endcase
        end
      end
      S_SETTLE: begin
        if (cnt_q == 4'd0) begin
          res_data_d  = add_g;
          res_carry_d = flag_carry;
          res_ovf_d   = flag_ovf;
          acc_d       = add_g;
          state_d     = S_OUT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_OUT: begin
        if (res_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      op_a_q      <= '0;
      add_d_q     <= '0;
      add_f_q     <= '0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      res_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      op_a_q      <= op_a_d;
      add_d_q     <= add_d_d;
      add_f_q     <= add_f_d;
      res_data_q  <= res_data_d;
      res_carry_q <= res_carry_d;
      res_ovf_q   <= res_ovf_d;
    end
  end

  assign add_d     = add_d_q;
  assign add_f     = add_f_q;
  assign res_valid = (state_q == S_OUT);
  assign res_data  = res_data_q;
  assign res_carry = res_carry_q;
  assign res_ovf   = res_ovf_q;
  assign busy      = (state_q == S_SETTLE) || (state_q == S_OUT);

endmodule
